riscv_mc_controller: RTL and testbench
======================================

# riscv_mc_controller

Main control FSM for the multi-cycle RV32I datapath. It takes the opcode and function fields that the instruction-field splitter extracts from the instruction register, plus the ALU flags. It steps each instruction through fetch, decode, execute, memory and writeback, and drives every mux select and write enable in the datapath. It also waits on a memory-ready handshake and flags unsupported encodings.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active low
- op  in  7  opcode from the instruction register
- funct3  in  3  instruction bits [14:12]
- funct7  in  7  instruction bits [31:25]
- zero  in  1  ALU result is zero
- neg  in  1  ALU result sign bit (signed compare)
- mem_ready  in  1  memory has completed the current access
- pc_write  out  1  load PC from the result bus
- adr_src  out  1  memory address select: 0 = PC, 1 = result bus
- mem_write  out  1  memory write request
- ir_write  out  1  latch the instruction register and OldPC
- result_src  out  2  result bus select: 00 = ALUOut, 01 = data register, 10 = ALU result, 11 = immediate
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = register A
- alu_src_b  out  2  ALU B select: 00 = register B, 01 = immediate, 10 = constant 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu
- imm_src  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
- reg_write  out  1  register file write enable
- illegal  out  1  one-cycle pulse on an unsupported encoding
- retire  out  1  one-cycle pulse in the final state of each instruction
- state  out  4  current state, for debug

## Operation
- **Outputs:** Moore-style, decoded from the current state. Exceptions are ALU and immediate selects that depend on the latched op/funct3/funct7/flags. Any select not listed for a state is 0 and don't-care.
- **FETCH**
  - Drives adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10.
  - ir_write and pc_write are asserted only when mem_ready=1; the FSM stays in FETCH while mem_ready=0.
  - Next state is DECODE.
- **DECODE**
  - Computes OldPC+imm: alu_src_a=01, alu_src_b=01, add. imm_src is B for op 1100011, J for 1101111, otherwise B.
  - Next state by op:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 or 0100011 → MEMADR
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR_ADR
    - 0110111 → LUI
    - anything else, or an unsupported funct → illegal=1, next FETCH.
- **EXEC_R**
  - alu_src_a=10, alu_src_b=00.
  - funct3 decode: 000 gives sub if funct7[5], else add; 111 and; 110 or; 100 xor; 010 slt; 011 sltu. Any other funct3 is illegal and is detected in DECODE.
  - Next state is ALUWB.
- **EXEC_I:** alu_src_a=10, alu_src_b=01, imm_src=I. Same funct3 map as EXEC_R, except 000 is always add. Next state is ALUWB.
- **ALUWB:** reg_write=1, result_src=00, retire=1. Next state is FETCH.
- **MEMADR:** alu_src_a=10, alu_src_b=01, add. imm_src is I for loads and S for stores. Next state is MEMREAD for a load, MEMWRITE for a store.
- **MEMREAD:** adr_src=1, result_src=00. Holds until mem_ready=1, then goes to MEMWB.
- **MEMWB:** reg_write=1, result_src=01, retire=1. Next state is FETCH.
- **MEMWRITE**
  - adr_src=1, result_src=00, mem_write=1, held high until mem_ready=1.
  - retire=1 in the cycle where mem_ready=1; that cycle goes to FETCH.
- **BRANCH**
  - alu_src_a=10, alu_src_b=00, sub, result_src=00, retire=1.
  - Taken condition by funct3: 000 zero; 001 !zero; 100 neg; 101 !neg.
  - pc_write = taken. funct3 010, 011, 110 or 111 is illegal in DECODE.
  - Next state is FETCH.
- **JALR_ADR:** alu_src_a=10, alu_src_b=01, imm_src=I, add. Next state is JAL.
- **JAL:** pc_write=1, result_src=00 (target from ALUOut). ALU computes OldPC+4 (alu_src_a=01, alu_src_b=10, add). Next state is ALUWB, which writes the link address.
- **LUI:** imm_src=U, result_src=11, reg_write=1, retire=1. Next state is FETCH.

## Timing
- **Reset**
  - With rst_n=0 at a rising edge, state becomes FETCH.
  - While rst_n=0, pc_write, ir_write, mem_write, reg_write, illegal and retire are forced to 0.
  - Reset has priority in every state, including mid-wait in MEMREAD or MEMWRITE; the pending access is abandoned.
- **Instruction latency with mem_ready held at 1**
  - R-type, I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch: 3 cycles
  - jal: 4 cycles
  - jalr: 5 cycles
  - lui: 3 cycles
  - An illegal encoding takes 2 cycles.
  - Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- **Handshake:** mem_write and adr_src are stable from state entry until the cycle in which mem_ready=1 is sampled. Enables are never asserted twice for one access.
- **Pulses:** retire is asserted exactly once per legal instruction; illegal is asserted exactly once per illegal one. The two are never asserted in the same cycle.

## Test plan
- Reset mid-MEMREAD with mem_ready=0: deassert rst_n for one edge → state=FETCH, all enables 0; the next instruction fetches normally.
- add then sub (op 0110011, funct3 000, funct7 0000000 / 0100000), mem_ready=1 → 4 cycles each; alu_control 000 then 001; reg_write high only in ALUWB; two retire pulses.
- lw with mem_ready low for 3 cycles in MEMREAD → 8-cycle instruction; adr_src=1 held throughout; reg_write with result_src=01 exactly once.
- beq with zero=1, then bne with zero=1 → pc_write=1 in BRANCH for beq, 0 for bne; each takes 3 cycles.
- jalr → sequence FETCH, DECODE, JALR_ADR, JAL, ALUWB; pc_write in JAL; reg_write with result_src=00 in ALUWB.
- op 1111111, then R-type funct3 000 with funct7 0000001 → illegal pulse in DECODE, return to FETCH, no retire and no write enables.

Source files
------------

// File: rtl/riscv_mc_controller.sv
// riscv_mc_controller
// Main control FSM for the multi-cycle RV32I datapath. Each instruction is
// stepped through fetch, decode, execute, memory and writeback, and every mux
// select and write enable in the datapath is decoded from the current state.
//
// Ports:
//   clk, rst_n              rising-edge clock, synchronous active-low reset
//   op, funct3, funct7      instruction fields from the instruction register
//   zero, neg               ALU flags (result zero, result sign)
//   mem_ready               memory has completed the current access
//   pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
//   alu_src_b, alu_control, imm_src, reg_write   datapath controls
//   illegal                 one-cycle pulse on an unsupported encoding
//   retire                  one-cycle pulse in the last state of an instruction
//   state                   current state encoding, for debug
//
// State encoding (visible on the state port):
//   0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE, 6 EXEC_R,
//   7 EXEC_I, 8 ALUWB, 9 BRANCH, 10 JAL, 11 JALR_ADR, 12 LUI
module riscv_mc_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       neg,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src,
  output logic       reg_write,
  output logic       illegal,
  output logic       retire,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR_ADR = 4'd11,
    S_LUI      = 4'd12
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t state_q, state_d;

  logic decodeIllegal;
  logic branchTaken;
  logic pcWriteRaw, memWriteRaw, irWriteRaw, regWriteRaw, illegalRaw, retireRaw;

  // Shared funct3 -> ALU operation map for register and immediate forms;
  // subtract only applies to the register form with funct7[5] set.
  function automatic logic [2:0] aluOp(input logic [2:0] f3, input logic subtract);
    case (f3)
      3'b000:  aluOp = subtract ? 3'b001 : 3'b000;
      3'b111:  aluOp = 3'b010;
      3'b110:  aluOp = 3'b011;
      3'b100:  aluOp = 3'b100;
      3'b010:  aluOp = 3'b101;
      3'b011:  aluOp = 3'b110;
      default: aluOp = 3'b000;
    endcase
  endfunction

  // Everything the datapath cannot execute is caught here, so later states
  // never see an unsupported funct3/funct7. Shifts (funct3 001/101) are not
  // implemented; memory accesses are word-only.
  always_comb begin
    decodeIllegal = 1'b1;
    case (op)
      OP_R:      decodeIllegal = !((funct7 == 7'b0000000 && funct3 != 3'b001 && funct3 != 3'b101) ||
                                   (funct7 == 7'b0100000 && funct3 == 3'b000));
      OP_I:      decodeIllegal = (funct3 == 3'b001) || (funct3 == 3'b101);
      OP_LOAD:   decodeIllegal = (funct3 != 3'b010);
      OP_STORE:  decodeIllegal = (funct3 != 3'b010);
      OP_BRANCH: decodeIllegal = funct3[1];
      OP_JAL:    decodeIllegal = 1'b0;
      OP_JALR:   decodeIllegal = (funct3 != 3'b000);
      OP_LUI:    decodeIllegal = 1'b0;
      default:   decodeIllegal = 1'b1;
    endcase
  end

  // Branch condition from the flags of rs1 - rs2 computed in BRANCH.
  always_comb begin
    branchTaken = 1'b0;
    case (funct3)
      3'b000:  branchTaken = zero;
      3'b001:  branchTaken = !zero;
      3'b100:  branchTaken = neg;
      3'b101:  branchTaken = !neg;
      default: branchTaken = 1'b0;
    endcase
  end

  // Next-state logic; FETCH, MEMREAD and MEMWRITE hold until mem_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (decodeIllegal) state_d = S_FETCH;
        else begin
          case (op)
            OP_R:      state_d = S_EXEC_R;
            OP_I:      state_d = S_EXEC_I;
            OP_LOAD:   state_d = S_MEMADR;
            OP_STORE:  state_d = S_MEMADR;
            OP_BRANCH: state_d = S_BRANCH;
            OP_JAL:    state_d = S_JAL;
            OP_JALR:   state_d = S_JALR_ADR;
            OP_LUI:    state_d = S_LUI;
            default:   state_d = S_FETCH;
          endcase
        end
      end
      S_EXEC_R:   state_d = S_ALUWB;
      S_EXEC_I:   state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JALR_ADR: state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      S_LUI:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Moore decode of datapath controls; only the ALU op, immediate format,
  // branch pc_write and handshake-qualified enables look at inputs.
  always_comb begin
    pcWriteRaw  = 1'b0;
    adr_src     = 1'b0;
    memWriteRaw = 1'b0;
    irWriteRaw  = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    imm_src     = 3'b000;
    regWriteRaw = 1'b0;
    illegalRaw  = 1'b0;
    retireRaw   = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        irWriteRaw = mem_ready;
        pcWriteRaw = mem_ready;
      end
      S_DECODE: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b01;
        imm_src    = (op == OP_JAL) ? 3'b011 : 3'b010;
        illegalRaw = decodeIllegal;
      end
      S_EXEC_R: begin
        alu_src_a   = 2'b10;
        alu_control = aluOp(funct3, funct7[5]);
      end
      S_EXEC_I: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = aluOp(funct3, 1'b0);
      end
      S_ALUWB: begin
        regWriteRaw = 1'b1;
        retireRaw   = 1'b1;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (op == OP_STORE) ? 3'b001 : 3'b000;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src  = 2'b01;
        regWriteRaw = 1'b1;
        retireRaw   = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        memWriteRaw = 1'b1;
        retireRaw   = mem_ready;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = 3'b001;
        pcWriteRaw  = branchTaken;
        retireRaw   = 1'b1;
      end
      S_JALR_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_JAL: begin
        pcWriteRaw = 1'b1;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
      end
      S_LUI: begin
        imm_src     = 3'b100;
        result_src  = 2'b11;
        regWriteRaw = 1'b1;
        retireRaw   = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are suppressed for the whole time reset is held, so an access
  // interrupted by reset never commits.
  assign pc_write  = pcWriteRaw  & rst_n;
  assign mem_write = memWriteRaw & rst_n;
  assign ir_write  = irWriteRaw  & rst_n;
  assign reg_write = regWriteRaw & rst_n;
  assign illegal   = illegalRaw  & rst_n;
  assign retire    = retireRaw   & rst_n;
  assign state     = state_q;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// tb_riscv_mc_controller
// Cycle-by-cycle table of inputs and expected controller outputs, followed
// by per-instruction latency sequences measured from FETCH to retire/illegal.
module tb_riscv_mc_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero, neg, mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;
  logic       reg_write, illegal, retire;
  logic [3:0] state;

  localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4,
                         MW = 4'd5, XR = 4'd6, XI = 4'd7, WB = 4'd8, BR = 4'd9,
                         JL = 4'd10, JA = 4'd11, LU = 4'd12;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                         ST = 7'b0100011, B = 7'b1100011, J = 7'b1101111,
                         JR = 7'b1100111, LUIOP = 7'b0110111;

  typedef struct {
    string      name;
    logic       rstN;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       zero;
    logic       neg;
    logic       memReady;
    logic [22:0] expected;
  } vec_t;

  vec_t vecs[$];
  int   checkCount = 0;
  int   passCount  = 0;

  riscv_mc_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .neg(neg), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
    .reg_write(reg_write), .illegal(illegal), .retire(retire), .state(state)
  );

  always #5 clk = ~clk;

  // Bundle order: state, pc_write, adr_src, mem_write, ir_write, result_src,
  // alu_src_a, alu_src_b, alu_control, imm_src, reg_write, illegal, retire
  function automatic logic [22:0] packOut(input logic [3:0] st, input logic pcw, input logic adr,
                                          input logic mw, input logic irw, input logic [1:0] rs,
                                          input logic [1:0] a, input logic [1:0] b,
                                          input logic [2:0] alu, input logic [2:0] imm,
                                          input logic rw, input logic ill, input logic ret);
    packOut = {st, pcw, adr, mw, irw, rs, a, b, alu, imm, rw, ill, ret};
  endfunction

  function automatic logic [22:0] eFetch(input logic go);
    eFetch = packOut(FE, go, 1'b0, 1'b0, go, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [22:0] eDecode(input logic [2:0] imm, input logic ill);
    eDecode = packOut(DE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 1'b0, ill, 1'b0);
  endfunction

  function automatic logic [22:0] eAluwb();
    eAluwb = packOut(WB, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1);
  endfunction

  task automatic addVec(input string name, input logic rn, input logic [6:0] o, input logic [2:0] f3,
                        input logic [6:0] f7, input logic z, input logic n, input logic mr,
                        input logic [22:0] e);
    vec_t v;
    v.name = name; v.rstN = rn; v.op = o; v.f3 = f3; v.f7 = f7;
    v.zero = z; v.neg = n; v.memReady = mr; v.expected = e;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  // Drive one cycle's inputs after the falling edge and sample mid-cycle.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst_n = v.rstN; op = v.op; funct3 = v.f3; funct7 = v.f7;
    zero = v.zero; neg = v.neg; mem_ready = v.memReady;
    #2;
    checkOutput(v.name,
                {9'd0, state, pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                 alu_src_b, alu_control, imm_src, reg_write, illegal, retire},
                {9'd0, v.expected});
  endtask

  // Counts cycles from FETCH until retire or illegal, with a bounded wait.
  task automatic measureLatency(input string name, input logic [6:0] o, input logic [2:0] f3,
                                input logic [6:0] f7, input int expected);
    int  cycles = 0;
    bit  done   = 0;
    while (!done && cycles < 20) begin
      @(negedge clk);
      rst_n = 1'b1; op = o; funct3 = f3; funct7 = f7;
      zero = 1'b0; neg = 1'b0; mem_ready = 1'b1;
      #2;
      cycles++;
      if (retire === 1'b1 || illegal === 1'b1) done = 1;
    end
    checkOutput(name, cycles, expected);
  endtask

  initial begin
    rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
    zero = 1'b0; neg = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);

    // reset held: FETCH with enables suppressed
    addVec("rst_hold", 0, R, 3'b000, 7'h00, 0, 0, 1, eFetch(0));
    // add
    addVec("add_f",  1, R, 3'b000, 7'h00, 0, 0, 1, eFetch(1));
    addVec("add_d",  1, R, 3'b000, 7'h00, 0, 0, 1, eDecode(3'b010, 0));
    addVec("add_x",  1, R, 3'b000, 7'h00, 0, 0, 1, packOut(XR, 0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0,0,0));
    addVec("add_wb", 1, R, 3'b000, 7'h00, 0, 0, 1, eAluwb());
    // sub
    addVec("sub_f",  1, R, 3'b000, 7'h20, 0, 0, 1, eFetch(1));
    addVec("sub_d",  1, R, 3'b000, 7'h20, 0, 0, 1, eDecode(3'b010, 0));
    addVec("sub_x",  1, R, 3'b000, 7'h20, 0, 0, 1, packOut(XR, 0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0,0,0));
    addVec("sub_wb", 1, R, 3'b000, 7'h20, 0, 0, 1, eAluwb());
    // sltu
    addVec("sltu_f", 1, R, 3'b011, 7'h00, 0, 0, 1, eFetch(1));
    addVec("sltu_d", 1, R, 3'b011, 7'h00, 0, 0, 1, eDecode(3'b010, 0));
    addVec("sltu_x", 1, R, 3'b011, 7'h00, 0, 0, 1, packOut(XR, 0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b110, 3'b000, 0,0,0));
    addVec("sltu_wb",1, R, 3'b011, 7'h00, 0, 0, 1, eAluwb());
    // xori
    addVec("xori_f", 1, I, 3'b100, 7'h00, 0, 0, 1, eFetch(1));
    addVec("xori_d", 1, I, 3'b100, 7'h00, 0, 0, 1, eDecode(3'b010, 0));
    addVec("xori_x", 1, I, 3'b100, 7'h00, 0, 0, 1, packOut(XI, 0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b100, 3'b000, 0,0,0));
    addVec("xori_wb",1, I, 3'b100, 7'h00, 0, 0, 1, eAluwb());
    // addi with immediate bit 10 set: still add
    addVec("addi_f", 1, I, 3'b000, 7'h20, 0, 0, 1, eFetch(1));
    addVec("addi_d", 1, I, 3'b000, 7'h20, 0, 0, 1, eDecode(3'b010, 0));
    addVec("addi_x", 1, I, 3'b000, 7'h20, 0, 0, 1, packOut(XI, 0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0,0,0));
    addVec("addi_wb",1, I, 3'b000, 7'h20, 0, 0, 1, eAluwb());
    // lw with three wait cycles in MEMREAD
    addVec("lw_f",   1, LD, 3'b010, 7'h00, 0, 0, 1, eFetch(1));
    addVec("lw_d",   1, LD, 3'b010, 7'h00, 0, 0, 1, eDecode(3'b010, 0));
    addVec("lw_ma",  1, LD, 3'b010, 7'h00, 0, 0, 1, packOut(MA, 0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0,0,0));
    for (int k = 0; k < 3; k++)
      addVec("lw_wait", 1, LD, 3'b010, 7'h00, 0, 0, 0, packOut(MR, 0,1,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0,0,0));
    addVec("lw_rdy", 1, LD, 3'b010, 7'h00, 0, 0, 1, packOut(MR, 0,1,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0,0,0));
    addVec("lw_wb",  1, LD, 3'b010, 7'h00, 0, 0, 1, packOut(MWB, 0,0,0,0, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1,0,1));
    // sw with one fetch stall and one write wait
    addVec("sw_fst", 1, ST, 3'b010, 7'h00, 0, 0, 0, eFetch(0));
    addVec("sw_f",   1, ST, 3'b010, 7'h00, 0, 0, 1, eFetch(1));
    addVec("sw_d",   1, ST, 3'b010, 7'h00, 0, 0, 1, eDecode(3'b010, 0));
    addVec("sw_ma",  1, ST, 3'b010, 7'h00, 0, 0, 1, packOut(MA, 0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0,0,0));
    addVec("sw_wait",1, ST, 3'b010, 7'h00, 0, 0, 0, packOut(MW, 0,1,1,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0,0,0));
    addVec("sw_rdy", 1, ST, 3'b010, 7'h00, 0, 0, 1, packOut(MW, 0,1,1,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0,0,1));
    // beq taken, bne not taken, blt taken
    addVec("beq_f",  1, B, 3'b000, 7'h00, 1, 0, 1, eFetch(1));
    addVec("beq_d",  1, B, 3'b000, 7'h00, 1, 0, 1, eDecode(3'b010, 0));
    addVec("beq_br", 1, B, 3'b000, 7'h00, 1, 0, 1, packOut(BR, 1,0,0,0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0,0,1));
    addVec("bne_f",  1, B, 3'b001, 7'h00, 1, 0, 1, eFetch(1));
    addVec("bne_d",  1, B, 3'b001, 7'h00, 1, 0, 1, eDecode(3'b010, 0));
    addVec("bne_br", 1, B, 3'b001, 7'h00, 1, 0, 1, packOut(BR, 0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0,0,1));
    addVec("blt_f",  1, B, 3'b100, 7'h00, 0, 1, 1, eFetch(1));
    addVec("blt_d",  1, B, 3'b100, 7'h00, 0, 1, 1, eDecode(3'b010, 0));
    addVec("blt_br", 1, B, 3'b100, 7'h00, 0, 1, 1, packOut(BR, 1,0,0,0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0,0,1));
    // jal
    addVec("jal_f",  1, J, 3'b000, 7'h00, 0, 0, 1, eFetch(1));
    addVec("jal_d",  1, J, 3'b000, 7'h00, 0, 0, 1, eDecode(3'b011, 0));
    addVec("jal_j",  1, J, 3'b000, 7'h00, 0, 0, 1, packOut(JL, 1,0,0,0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0,0,0));
    addVec("jal_wb", 1, J, 3'b000, 7'h00, 0, 0, 1, eAluwb());
    // jalr
    addVec("jalr_f", 1, JR, 3'b000, 7'h00, 0, 0, 1, eFetch(1));
    addVec("jalr_d", 1, JR, 3'b000, 7'h00, 0, 0, 1, eDecode(3'b010, 0));
    addVec("jalr_a", 1, JR, 3'b000, 7'h00, 0, 0, 1, packOut(JA, 0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0,0,0));
    addVec("jalr_j", 1, JR, 3'b000, 7'h00, 0, 0, 1, packOut(JL, 1,0,0,0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0,0,0));
    addVec("jalr_wb",1, JR, 3'b000, 7'h00, 0, 0, 1, eAluwb());
    // lui
    addVec("lui_f",  1, LUIOP, 3'b000, 7'h00, 0, 0, 1, eFetch(1));
    addVec("lui_d",  1, LUIOP, 3'b000, 7'h00, 0, 0, 1, eDecode(3'b010, 0));
    addVec("lui_u",  1, LUIOP, 3'b000, 7'h00, 0, 0, 1, packOut(LU, 0,0,0,0, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100, 1,0,1));
    // illegal opcode, then R-type with bad funct7
    addVec("ill_f",  1, 7'b1111111, 3'b000, 7'h00, 0, 0, 1, eFetch(1));
    addVec("ill_d",  1, 7'b1111111, 3'b000, 7'h00, 0, 0, 1, eDecode(3'b010, 1));
    addVec("ilr_f",  1, R, 3'b000, 7'h01, 0, 0, 1, eFetch(1));
    addVec("ilr_d",  1, R, 3'b000, 7'h01, 0, 0, 1, eDecode(3'b010, 1));
    // reset mid-MEMREAD, then a lui completes normally
    addVec("rlw_f",  1, LD, 3'b010, 7'h00, 0, 0, 1, eFetch(1));
    addVec("rlw_d",  1, LD, 3'b010, 7'h00, 0, 0, 1, eDecode(3'b010, 0));
    addVec("rlw_ma", 1, LD, 3'b010, 7'h00, 0, 0, 1, packOut(MA, 0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0,0,0));
    addVec("rlw_mr", 1, LD, 3'b010, 7'h00, 0, 0, 0, packOut(MR, 0,1,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0,0,0));
    addVec("rlw_rst",0, LD, 3'b010, 7'h00, 0, 0, 0, packOut(MR, 0,1,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0,0,0));
    addVec("rlu_f",  1, LUIOP, 3'b000, 7'h00, 0, 0, 1, eFetch(1));
    addVec("rlu_d",  1, LUIOP, 3'b000, 7'h00, 0, 0, 1, eDecode(3'b010, 0));
    addVec("rlu_u",  1, LUIOP, 3'b000, 7'h00, 0, 0, 1, packOut(LU, 0,0,0,0, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100, 1,0,1));
    // reset mid-MEMWRITE: mem_write suppressed while reset is held
    addVec("rsw_f",  1, ST, 3'b010, 7'h00, 0, 0, 1, eFetch(1));
    addVec("rsw_d",  1, ST, 3'b010, 7'h00, 0, 0, 1, eDecode(3'b010, 0));
    addVec("rsw_ma", 1, ST, 3'b010, 7'h00, 0, 0, 1, packOut(MA, 0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0,0,0));
    addVec("rsw_mw", 1, ST, 3'b010, 7'h00, 0, 0, 0, packOut(MW, 0,1,1,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0,0,0));
    addVec("rsw_rst",0, ST, 3'b010, 7'h00, 0, 0, 0, packOut(MW, 0,1,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0,0,0));
    addVec("rsw_fe", 1, ST, 3'b010, 7'h00, 0, 0, 0, eFetch(0));

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // End-to-end latencies with mem_ready held high
    measureLatency("lat_add",  R,     3'b000, 7'h00, 4);
    measureLatency("lat_lw",   LD,    3'b010, 7'h00, 5);
    measureLatency("lat_sw",   ST,    3'b010, 7'h00, 4);
    measureLatency("lat_beq",  B,     3'b000, 7'h00, 3);
    measureLatency("lat_jal",  J,     3'b000, 7'h00, 4);
    measureLatency("lat_jalr", JR,    3'b000, 7'h00, 5);
    measureLatency("lat_lui",  LUIOP, 3'b000, 7'h00, 3);
    measureLatency("lat_ill",  7'b0000000, 3'b000, 7'h00, 2);
    measureLatency("lat_sll",  I,     3'b001, 7'h00, 2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
